// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: controller modes, init-table
// entry layout, sequencer state encoding and the default codec bring-up table.
package i2c_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Init-table entry layout (16 bits)
  localparam int TYPE_BIT  = 15;
  localparam int ADDR_MSB  = 14;
  localparam int ADDR_LSB  = 8;
  localparam int DATA_MSB  = 7;
  localparam int DATA_LSB  = 0;
  localparam int COUNT_MSB = 14;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_ISSUE     = 4'd2,
    ST_ARMED     = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_GAP       = 4'd5,
    ST_DELAY     = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } seq_state_e;

  typedef logic [255:0][15:0] rom_table_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Codec bring-up: soft reset, settle, then power/format/sampling setup.
  function automatic rom_table_t codec_table();
    rom_table_t t = '0;
    t[0]  = 16'h1E00;
    t[1]  = 16'h8010;
    t[2]  = 16'h0C10;
    t[3]  = 16'h0E02;
    t[4]  = 16'h1000;
    t[5]  = 16'h0A00;
    t[6]  = 16'h0812;
    t[7]  = 16'h0079;
    t[8]  = 16'h0279;
    t[9]  = 16'h0417;
    t[10] = 16'h0617;
    t[11] = 16'h8004;
    t[12] = 16'h0C00;
    t[13] = 16'h1201;
    t[14] = 16'h8001;
    t[15] = 16'h0A06;
    return t;
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Combinational init-table lookup; the table contents come in as a parameter.
module i2c_init_rom
  import i2c_pkg::*;
#(
  parameter rom_table_t TABLE = codec_table()
) (
  input  logic [7:0]  index,
  output logic [15:0] data
);

  // NOTE: the table is a parameter-constant lookup, so there is no storage to reset.
  assign data = TABLE[index];

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table, issuing single-byte writes to the I2C controller via
// its enable/ready handshake, with programmed delays and a ready timeout.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int         NUM_ENTRIES    = 16,
  parameter int         GAP_CYCLES     = 32,
  parameter int         DELAY_SCALE    = 256,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter rom_table_t INIT_TABLE     = codec_table()
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ctrl_ready,
  output logic       ctrl_enable,
  output logic       ctrl_mode,
  output logic [6:0] ctrl_addr,
  output logic [7:0] ctrl_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] index
);

  localparam int         DW   = 15 + $clog2(DELAY_SCALE);
  localparam int         GW   = cnt_width(GAP_CYCLES);
  localparam int         TW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [7:0] LAST = 8'(NUM_ENTRIES - 1);

  seq_state_e    state, state_next;
  logic [15:0]   entry;
  logic [DW-1:0] delay_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          is_delay, delay_zero, last_entry;
  logic          delay_end, gap_end, timeout_hit;
  logic          launch, step;

  i2c_init_rom #(.TABLE(INIT_TABLE)) u_rom (
    .index (index),
    .data  (entry)
  );

  assign is_delay    = entry[TYPE_BIT];
  assign delay_zero  = (entry[COUNT_MSB:0] == 15'd0);
  assign last_entry  = (index == LAST);
  assign delay_end   = (delay_cnt == '0);
  assign gap_end     = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign ctrl_mode   = WRITE;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next  = state;
    ctrl_enable = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    launch      = 1'b0;
    step        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          launch     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!is_delay)       state_next = ST_ISSUE;
        else if (!delay_zero) state_next = ST_DELAY;
        else                 step       = 1'b1;
      end
      ST_ISSUE: begin
        ctrl_enable = 1'b1;
        state_next  = ST_ARMED;
      end
      // The controller's ready is ~enable-derived, so it is only trusted from here on
      ST_ARMED:     state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (ctrl_ready)       state_next = ST_GAP;
        else if (timeout_hit) state_next = ST_ERROR;
      end
      ST_GAP:   step = gap_end;
      ST_DELAY: step = delay_end;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          launch     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
        if (start) begin
          launch     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (step) state_next = last_entry ? ST_DONE : ST_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index       <= '0;
      ctrl_addr   <= '0;
      ctrl_byte   <= '0;
      delay_cnt   <= '0;
      gap_cnt     <= '0;
      timeout_cnt <= '0;
    end else begin
      if (launch)                   index <= '0;
      else if (step && !last_entry) index <= index + 8'd1;

      if (state == ST_FETCH) begin
        if (!is_delay) begin
          ctrl_addr <= entry[ADDR_MSB:ADDR_LSB];
          ctrl_byte <= entry[DATA_MSB:DATA_LSB];
        end else if (!delay_zero) begin
          delay_cnt <= DW'(entry[COUNT_MSB:0]) * DW'(DELAY_SCALE) - DW'(1);
        end
      end else if (state == ST_DELAY && !delay_end) begin
        delay_cnt <= delay_cnt - DW'(1);
      end

      if (state == ST_ISSUE)
        timeout_cnt <= '0;
      else if ((state == ST_ARMED || state == ST_WAIT_DONE) && !timeout_hit)
        timeout_cnt <= timeout_cnt + TW'(1);

      if (state == ST_WAIT_DONE)
        gap_cnt <= '0;
      else if (state == ST_GAP && !gap_end)
        gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule
